// File: rtl/axis_64_to_512_packer.sv
// axis_64_to_512_packer: packs RATIO narrow AXI-Stream beats into one wide beat, lane 0 first,
// with TLAST-closed partial words zero-padded and a one-word pending buffer for output stalls.
module axis_64_to_512_packer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 512,
  parameter int RATIO = C_M00_AXIS_TDATA_WIDTH / C_S00_AXIS_TDATA_WIDTH
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic [15:0]                         frame_count
);
  localparam int SW = C_S00_AXIS_TDATA_WIDTH;
  localparam int MW = C_M00_AXIS_TDATA_WIDTH;
  localparam int SK = SW / 8;
  localparam int MK = MW / 8;
  localparam int IW = $clog2(RATIO);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [MW-1:0] acc_q, acc_d, acc_w, m_data_q, m_data_d;
  logic [MK-1:0] keep_q, keep_d, keep_w, m_keep_q, m_keep_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic last_q, last_d, m_valid_q, m_valid_d, m_last_q, m_last_d, s_ready_q, s_ready_d;
  logic accept, complete, out_free;
  always_comb begin
    acc_w = acc_q;
    keep_w = keep_q;
    acc_w[idx_q*SW +: SW] = S_AXIS_TDATA;
    keep_w[idx_q*SK +: SK] = '1;
    accept = S_AXIS_TVALID && s_ready_q;
    complete = accept && (S_AXIS_TLAST || idx_q == IW'(RATIO - 1));
    out_free = !m_valid_q || M_AXIS_TREADY;
    state_d = state_q;
    acc_d = acc_q;
    keep_d = keep_q;
    idx_d = idx_q;
    last_d = last_q;
    m_data_d = m_data_q;
    m_keep_d = m_keep_q;
    m_last_d = m_last_q;
    m_valid_d = m_valid_q && !M_AXIS_TREADY;
    frame_count_d = frame_count_q + 16'(m_valid_q && M_AXIS_TREADY && m_last_q);
    if (state_q == HOLD) begin
      if (out_free) begin
        m_data_d = acc_q;
        m_keep_d = keep_q;
        m_last_d = last_q;
        m_valid_d = 1'b1;
        acc_d = '0;
        keep_d = '0;
        state_d = FILL;
      end
    end else if (accept) begin
      idx_d = complete ? '0 : idx_q + 1'b1;
      if (complete && out_free) begin
        m_data_d = acc_w;
        m_keep_d = keep_w;
        m_last_d = S_AXIS_TLAST;
        m_valid_d = 1'b1;
        acc_d = '0;
        keep_d = '0;
      end else begin
        // a closed word that cannot leave parks in the accumulator until the output frees
        acc_d = acc_w;
        keep_d = keep_w;
        last_d = S_AXIS_TLAST;
        state_d = complete ? HOLD : FILL;
      end
    end
    s_ready_d = state_d == FILL;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= FILL;
      acc_q <= '0;
      keep_q <= '0;
      idx_q <= '0;
      last_q <= 1'b0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      keep_q <= keep_d;
      idx_q <= idx_d;
      last_q <= last_d;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_last_q <= m_last_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TDATA = m_data_q;
  assign M_AXIS_TKEEP = m_keep_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST = m_last_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_axis_64_to_512_packer.sv
// tb_axis_64_to_512_packer: per-cycle vector table with hand-computed expectations,
// plus directed sequences for asynchronous reset and frame_count wrap.
module tb_axis_64_to_512_packer;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic [63:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [511:0] m_data;
  logic [63:0] m_keep;
  logic m_valid, m_last, m_ready = 1'b0;
  logic [15:0] frame_count;
  localparam logic [63:0] KF = '1;
  typedef struct {
    logic sv; logic [63:0] sd; logic sl; logic mr;
    logic er; logic ev; logic el; logic [63:0] ek; logic [511:0] ed; logic [15:0] fc;
  } vec_t;
  vec_t tab[$];
  int checks = 0, errors = 0;
  axis_64_to_512_packer dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TKEEP(m_keep), .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last),
    .M_AXIS_TREADY(m_ready), .frame_count(frame_count)
  );
  always #5 aclk = ~aclk;
  function automatic logic [511:0] wd(input logic [63:0] b, input int n);
    logic [511:0] w = '0;
    for (int k = 0; k < n; k++) w[k*64 +: 64] = b + 64'(k);
    return w;
  endfunction
  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic add(input logic sv, input logic [63:0] sd, input logic sl, input logic mr,
                     input logic er, input logic ev, input logic el, input logic [63:0] ek,
                     input logic [511:0] ed, input logic [15:0] fc);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.er = er; v.ev = ev; v.el = el; v.ek = ek; v.ed = ed; v.fc = fc;
    tab.push_back(v);
  endtask
  task automatic drive(input logic sv, input logic [63:0] sd, input logic sl, input logic mr);
    s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
  endtask
  task automatic run_tab(input string tag);
    foreach (tab[i]) begin
      drive(tab[i].sv, tab[i].sd, tab[i].sl, tab[i].mr);
      @(posedge aclk);
      #1;
      chk($sformatf("%s[%0d] s_tready", tag, i), s_ready, tab[i].er);
      chk($sformatf("%s[%0d] m_tvalid", tag, i), m_valid, tab[i].ev);
      chk($sformatf("%s[%0d] frame_count", tag, i), frame_count, tab[i].fc);
      if (tab[i].ev) begin
        chk($sformatf("%s[%0d] m_tlast", tag, i), m_last, tab[i].el);
        chk($sformatf("%s[%0d] m_tkeep", tag, i), m_keep, tab[i].ek);
        chk($sformatf("%s[%0d] m_tdata", tag, i), m_data, tab[i].ed);
      end
    end
    tab.delete();
  endtask
  initial begin
    #1 aresetn = 1'b0;
    #1;
    chk("reset s_tready", s_ready, 1'b1);
    chk("reset m_tvalid", m_valid, 1'b0);
    chk("reset m_tlast", m_last, 1'b0);
    chk("reset m_tdata", m_data, '0);
    chk("reset m_tkeep", m_keep, '0);
    chk("reset frame_count", frame_count, '0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int k = 0; k < 16; k++)
      add(1, 64'(k), k == 15, 1, 1, k == 7 || k == 15, k == 15, KF, k == 7 ? wd(0, 8) : wd(8, 8), 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    run_tab("full");
    add(1, 64'hA1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(1, 64'hA2, 0, 1, 1, 0, 0, 0, 0, 1);
    add(1, 64'hA3, 1, 1, 1, 1, 1, 64'h0000_0000_00FF_FFFF, wd(64'hA1, 3), 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 2);
    run_tab("partial");
    add(1, 64'h55, 1, 1, 1, 1, 1, 64'hFF, wd(64'h55, 1), 2);
    for (int k = 0; k < 8; k++)
      add(1, 64'h60 + 64'(k), 0, 1, 1, k == 7, 0, KF, wd(64'h60, 8), 3);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
    run_tab("single");
    for (int k = 0; k < 16; k++)
      add(1, 64'h10 + 64'(k), k == 15, 0, k != 15, k >= 7, 0, KF, wd(64'h10, 8), 3);
    add(1, 64'h99, 1, 0, 0, 1, 0, KF, wd(64'h10, 8), 3);
    add(0, 0, 0, 1, 1, 1, 1, KF, wd(64'h18, 8), 3);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 4);
    add(1, 64'h77, 1, 1, 1, 1, 1, 64'hFF, wd(64'h77, 1), 4);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 5);
    run_tab("bp");
    for (int k = 0; k < 13; k++) begin
      drive(1, k < 8 ? 64'hD0 + 64'(k) : 64'hC0 + 64'(k), 0, 0);
      @(posedge aclk);
      #1;
    end
    drive(0, 0, 0, 0);
    chk("pre-reset m_tvalid", m_valid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("midreset s_tready", s_ready, 1'b1);
    chk("midreset m_tvalid", m_valid, 1'b0);
    chk("midreset m_tdata", m_data, '0);
    chk("midreset m_tkeep", m_keep, '0);
    chk("midreset frame_count", frame_count, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int k = 0; k < 8; k++)
      add(1, 64'hB0 + 64'(k), 0, 1, 1, k == 7, 0, KF, wd(64'hB0, 8), 0);
    run_tab("postreset");
    for (int i = 0; i < 65536; i++) begin
      drive(1, 64'(i), 1, 1);
      @(posedge aclk);
      #1;
    end
    chk("wrap frame_count before", frame_count, 16'hFFFF);
    drive(0, 0, 0, 1);
    @(posedge aclk);
    #1;
    chk("wrap frame_count after", frame_count, 16'h0000);
    chk("wrap m_tvalid", m_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
